// File: rtl/csr_hpm_bank.sv
// csr_hpm_bank: hardware-performance-monitor CSR bank (mhpmcounter3.., mhpmcounterh3.., mhpmevent3..).
// Optional define HPM_OVF_IRQ_EN adds sticky per-counter overflow flags, overflow enables and irq_ovf.
module csr_hpm_bank #(
   parameter int NUM_CNT    = 4,
   parameter int CNT_WIDTH  = 64,
   parameter int NUM_EVENTS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   input  logic [1:0]            op,
   input  logic [11:0]           csr_addr,
   input  logic                  csr_wena,
   input  logic [31:0]           csr_wdata,
   input  logic                  csr_rena,
   output logic                  hit,
   output logic                  illegal,
   output logic [31:0]           csr_rdata,
   input  logic [NUM_EVENTS-1:0] events,
   input  logic [NUM_CNT-1:0]    inhibit,
   output logic                  irq_ovf
);

   localparam int         EVT_W      = $clog2(NUM_EVENTS + 1);
   localparam logic [1:0] CSR_RW     = 2'b01;
   localparam logic [1:0] CSR_RS     = 2'b10;
   localparam logic [1:0] CSR_RC     = 2'b11;
   localparam logic [6:0] BLK_EVT    = 7'h19;
   localparam logic [6:0] BLK_MLO    = 7'h58;
   localparam logic [6:0] BLK_MHI    = 7'h5C;
   localparam logic [6:0] BLK_ULO    = 7'h60;
   localparam logic [6:0] BLK_UHI    = 7'h64;
   localparam logic [5:0] IDX_END    = 6'(NUM_CNT + 3);

   logic [CNT_WIDTH-1:0] r_cnt [NUM_CNT];
   logic [EVT_W-1:0]     r_evt [NUM_CNT];
   logic                 r_valid;
   logic [31:0]          r_rdata;

   logic [CNT_WIDTH-1:0] w_cnt_nxt [NUM_CNT];
   logic [NUM_CNT-1:0]   w_match;
   logic [NUM_CNT-1:0]   w_inc;
   logic [NUM_CNT-1:0]   w_wr_lo;
   logic [NUM_CNT-1:0]   w_wr_hi;
   logic [NUM_CNT-1:0]   w_wr_evt;
   logic [NUM_CNT-1:0]   w_of_rd;
   logic [NUM_CNT-1:0]   w_ie_rd;
   logic [4:0]           w_idx;
   logic [6:0]           w_blk;
   logic                 w_is_evt;
   logic                 w_is_lo;
   logic                 w_is_hi;
   logic                 w_impl;
   logic                 w_accept;
   logic                 w_commit;
   logic [31:0]          w_word;
   logic [31:0]          w_old;
   logic [31:0]          w_wval;
   logic                 w_unused_rena;

   function automatic logic evt_pick(input logic [EVT_W-1:0] sel, input logic [NUM_EVENTS-1:0] ev);
      logic r;
      r = 1'b0;
      for (int k = 1; k <= NUM_EVENTS; k++) begin
         r = r | ((sel == EVT_W'(k)) & ev[k-1]);
      end
      return r;
   endfunction

   function automatic logic [31:0] evt_word(input logic [EVT_W-1:0] sel, input logic of_f, input logic ie_f);
      logic [31:0] w;
      w     = 32'(sel);
      w[31] = of_f;
      w[30] = ie_f;
      return w;
   endfunction

   function automatic logic [31:0] cnt_hi(input logic [CNT_WIDTH-1:0] c);
      return 32'(c >> 32);
   endfunction

   // Address decode: blocks of 32 CSRs, indices 0..2 of each block belong to csr_file
   assign w_idx    = csr_addr[4:0];
   assign w_blk    = csr_addr[11:5];
   assign w_is_evt = (w_blk == BLK_EVT);
   assign w_is_lo  = (w_blk == BLK_MLO) || (w_blk == BLK_ULO);
   assign w_is_hi  = (w_blk == BLK_MHI) || (w_blk == BLK_UHI);
   assign hit      = (w_is_evt || w_is_lo || w_is_hi) && (w_idx >= 5'd3);
   assign w_impl   = hit && ({1'b0, w_idx} < IDX_END);
   assign illegal  = valid_in && hit && csr_wena && (csr_addr[11:10] == 2'b11);

   assign ready_out     = !r_valid || ready_in;
   assign w_accept      = valid_in && ready_out;
   assign w_commit      = w_accept && csr_wena && !illegal && w_impl;
   assign valid_out     = r_valid;
   assign csr_rdata     = r_rdata;
   assign w_unused_rena = csr_rena;

   // Read mux: pre-increment value of the addressed register, 0 when unimplemented
   always_comb begin
      w_old   = 32'd0;
      w_word  = 32'd0;
      w_match = {NUM_CNT{1'b0}};
      for (int i = 0; i < NUM_CNT; i++) begin
         w_match[i] = w_impl && (w_idx == 5'(i + 3));
         w_word     = w_is_evt ? evt_word(r_evt[i], w_of_rd[i], w_ie_rd[i]) :
                      (w_is_lo ? r_cnt[i][31:0] : cnt_hi(r_cnt[i]));
         w_old      = w_old | ({32{w_match[i]}} & w_word);
      end
   end

   // Read-modify-write operand
   always_comb begin
      case (op)
         CSR_RW:  w_wval = csr_wdata;
         CSR_RS:  w_wval = w_old | csr_wdata;
         CSR_RC:  w_wval = w_old & ~csr_wdata;
         default: w_wval = w_old;
      endcase
   end

   // Counter next state: a software write to either half suppresses that cycle's increment
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         w_wr_evt[i] = w_commit && w_match[i] && w_is_evt;
         w_wr_lo[i]  = w_commit && w_match[i] && w_is_lo;
         w_wr_hi[i]  = w_commit && w_match[i] && w_is_hi;
         w_inc[i]    = evt_pick(r_evt[i], events) && !inhibit[i];
         if (w_wr_lo[i]) begin
            w_cnt_nxt[i] = {r_cnt[i][CNT_WIDTH-1:32], w_wval};
         end else if (w_wr_hi[i]) begin
            w_cnt_nxt[i] = CNT_WIDTH'({w_wval, r_cnt[i][31:0]});
         end else if (w_inc[i]) begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_WIDTH'(1'b1);
         end else begin
            w_cnt_nxt[i] = r_cnt[i];
         end
      end
   end

   // Result register and handshake; a stalled result holds its data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_rdata <= 32'd0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_rdata <= w_old;
      end else if (ready_in) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Counters and event selectors
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            r_cnt[i] <= {CNT_WIDTH{1'b0}};
            r_evt[i] <= {EVT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
            if (w_wr_evt[i]) begin
               r_evt[i] <= w_wval[EVT_W-1:0];
            end else begin
               r_evt[i] <= r_evt[i];
            end
         end
      end
   end

`ifdef HPM_OVF_IRQ_EN
   logic [NUM_CNT-1:0] r_of;
   logic [NUM_CNT-1:0] r_ie;
   logic [NUM_CNT-1:0] w_wrap;
   logic               r_irq;

   assign w_of_rd = r_of;
   assign w_ie_rd = r_ie;
   assign irq_ovf = r_irq;

   // Wrap happens only on a real increment of an all-ones counter
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         w_wrap[i] = w_inc[i] && !w_wr_lo[i] && !w_wr_hi[i] && (&r_cnt[i]);
      end
   end

   // Sticky overflow flags (hardware set beats software clear) and interrupt request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_of  <= {NUM_CNT{1'b0}};
         r_ie  <= {NUM_CNT{1'b0}};
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_of & r_ie);
         for (int i = 0; i < NUM_CNT; i++) begin
            if (w_wrap[i]) begin
               r_of[i] <= 1'b1;
            end else if (w_wr_evt[i]) begin
               r_of[i] <= w_wval[31];
            end else begin
               r_of[i] <= r_of[i];
            end
            if (w_wr_evt[i]) begin
               r_ie[i] <= w_wval[30];
            end else begin
               r_ie[i] <= r_ie[i];
            end
         end
      end
   end
`else
   assign w_of_rd = {NUM_CNT{1'b0}};
   assign w_ie_rd = {NUM_CNT{1'b0}};
   assign irq_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csr_hpm_bank.sv
// Testbench for csr_hpm_bank: decode table, directed sequences and randomized traffic vs a reference model.
module tb_csr_hpm_bank;

`ifdef HPM_OVF_IRQ_EN
   localparam int CW  = 40;
   localparam bit OVF = 1'b1;
`else
   localparam int CW  = 64;
   localparam bit OVF = 1'b0;
`endif
   localparam int NC = 4;
   localparam int NE = 8;
   localparam int EW = $clog2(NE + 1);
   localparam logic [1:0] RW = 2'b01;
   localparam logic [1:0] RS = 2'b10;
   localparam logic [1:0] RC = 2'b11;
   localparam longint unsigned MASK = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_in;
   logic          ready_out;
   logic          valid_out;
   logic          ready_in;
   logic [1:0]    op;
   logic [11:0]   csr_addr;
   logic          csr_wena;
   logic [31:0]   csr_wdata;
   logic          csr_rena;
   logic          hit;
   logic          illegal;
   logic [31:0]   csr_rdata;
   logic [NE-1:0] events;
   logic [NC-1:0] inhibit;
   logic          irq_ovf;

   int total = 0;
   int bad   = 0;

   // reference model state
   longint unsigned m_cnt [NC];
   int unsigned     m_sel [NC];
   bit              m_of  [NC];
   bit              m_ie  [NC];
   bit              m_valid;
   bit              m_irq;
   logic [31:0]     m_rdata;

   typedef struct {
      logic [11:0] addr;
      logic        wena;
      logic        exp_hit;
      logic        exp_ill;
   } dec_t;
   dec_t dec_tab [15];

   logic [11:0] pool [16] = '{12'h323, 12'h324, 12'h326, 12'h327, 12'h33F, 12'hB03, 12'hB04, 12'hB06,
                              12'hB07, 12'hB83, 12'hB85, 12'hC03, 12'hC84, 12'h340, 12'hB1F, 12'h000};

   csr_hpm_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .NUM_EVENTS(NE)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out), .valid_out(valid_out),
      .ready_in(ready_in), .op(op), .csr_addr(csr_addr), .csr_wena(csr_wena), .csr_wdata(csr_wdata),
      .csr_rena(csr_rena), .hit(hit), .illegal(illegal), .csr_rdata(csr_rdata), .events(events),
      .inhibit(inhibit), .irq_ovf(irq_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic acc(input logic [11:0] a, input logic [1:0] o, input logic we, input logic [31:0] wd,
                      output logic [31:0] rd, output logic h, output logic il);
      valid_in  = 1'b1;
      ready_in  = 1'b1;
      csr_addr  = a;
      op        = o;
      csr_wena  = we;
      csr_wdata = wd;
      csr_rena  = 1'b1;
      #1;
      h  = hit;
      il = illegal;
      @(posedge clk);
      #1;
      rd       = csr_rdata;
      valid_in = 1'b0;
      csr_wena = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      logic h;
      logic il;
      acc(a, RW, 1'b0, 32'd0, rd, h, il);
      chk(name, rd, exp);
   endtask

   function automatic bit m_hit(input int a);
      return (a >= 'h323 && a <= 'h33F) || (a >= 'hB03 && a <= 'hB1F) || (a >= 'hB83 && a <= 'hB9F) ||
             (a >= 'hC03 && a <= 'hC1F) || (a >= 'hC83 && a <= 'hC9F);
   endfunction

   function automatic logic [31:0] m_read(input int a);
      int n;
      if (!m_hit(a)) return 32'd0;
      n = (a % 32) - 3;
      if (n >= NC) return 32'd0;
      if (a < 'h400) return {(OVF & m_of[n]), (OVF & m_ie[n]), 30'd0} | 32'(m_sel[n]);
      if ((a / 128) % 2 == 1) return 32'(m_cnt[n] >> 32);
      return 32'(m_cnt[n]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_cnt[i] = 64'd0;
         m_sel[i] = 0;
         m_of[i]  = 1'b0;
         m_ie[i]  = 1'b0;
      end
      m_valid = 1'b0;
      m_irq   = 1'b0;
      m_rdata = 32'd0;
   endtask

   // one cycle of the model, taken with the inputs currently on the pins
   task automatic model_step();
      int a;
      int n;
      bit h;
      bit ill;
      bit rdy;
      bit accpt;
      bit irq_next;
      bit inc [NC];
      bit cwr [NC];
      logic [31:0] old;
      logic [31:0] nv;
      a   = int'(csr_addr);
      h   = m_hit(a);
      ill = valid_in && h && csr_wena && (a >= 'hC00);
      rdy = !m_valid || ready_in;
      chk("rnd_hit", hit, h);
      chk("rnd_illegal", illegal, ill);
      chk("rnd_ready", ready_out, rdy);
      accpt    = valid_in && rdy;
      old      = m_read(a);
      irq_next = 1'b0;
      for (int i = 0; i < NC; i++) begin
         if (OVF && m_of[i] && m_ie[i]) irq_next = 1'b1;
         inc[i] = (m_sel[i] >= 1) && (m_sel[i] <= NE) && events[m_sel[i] - 1] && !inhibit[i];
         cwr[i] = 1'b0;
      end
      n = (a % 32) - 3;
      if (accpt && csr_wena && !ill && h && n < NC) begin
         nv = (op == RW) ? csr_wdata : ((op == RS) ? (old | csr_wdata) : (old & ~csr_wdata));
         if (a < 'h400) begin
            m_sel[n] = nv % (1 << EW);
            m_of[n]  = OVF & nv[31];
            m_ie[n]  = OVF & nv[30];
         end else if ((a / 128) % 2 == 1) begin
            m_cnt[n] = ((64'(nv) << 32) | (m_cnt[n] & 64'hFFFF_FFFF)) & MASK;
            cwr[n]   = 1'b1;
         end else begin
            m_cnt[n] = (m_cnt[n] & ~64'hFFFF_FFFF) | 64'(nv);
            cwr[n]   = 1'b1;
         end
      end
      for (int i = 0; i < NC; i++) begin
         if (inc[i] && !cwr[i]) begin
            if (m_cnt[i] == MASK) begin
               m_cnt[i] = 64'd0;
               if (OVF) m_of[i] = 1'b1;
            end else begin
               m_cnt[i] = m_cnt[i] + 64'd1;
            end
         end
      end
      if (accpt) begin
         m_valid = 1'b1;
         m_rdata = old;
      end else if (ready_in) begin
         m_valid = 1'b0;
      end
      m_irq = irq_next;
   endtask

   initial begin
      logic [31:0] rd;
      logic        h;
      logic        il;
      int          r;

      dec_tab[0]  = '{12'h323, 1'b0, 1'b1, 1'b0};
      dec_tab[1]  = '{12'h322, 1'b0, 1'b0, 1'b0};
      dec_tab[2]  = '{12'h33F, 1'b1, 1'b1, 1'b0};
      dec_tab[3]  = '{12'h340, 1'b0, 1'b0, 1'b0};
      dec_tab[4]  = '{12'hB03, 1'b1, 1'b1, 1'b0};
      dec_tab[5]  = '{12'hB02, 1'b0, 1'b0, 1'b0};
      dec_tab[6]  = '{12'hB1F, 1'b1, 1'b1, 1'b0};
      dec_tab[7]  = '{12'hB20, 1'b0, 1'b0, 1'b0};
      dec_tab[8]  = '{12'hB83, 1'b1, 1'b1, 1'b0};
      dec_tab[9]  = '{12'hC03, 1'b1, 1'b1, 1'b1};
      dec_tab[10] = '{12'hC03, 1'b0, 1'b1, 1'b0};
      dec_tab[11] = '{12'hC9F, 1'b1, 1'b1, 1'b1};
      dec_tab[12] = '{12'hCA0, 1'b1, 1'b0, 1'b0};
      dec_tab[13] = '{12'hB07, 1'b1, 1'b1, 1'b0};
      dec_tab[14] = '{12'h000, 1'b1, 1'b0, 1'b0};

      reset = 1'b1; valid_in = 1'b0; ready_in = 1'b1; op = RW; csr_addr = 12'h000;
      csr_wena = 1'b0; csr_wdata = 32'd0; csr_rena = 1'b0; events = '0; inhibit = '0;
      #12;
      chk("rst_valid", valid_out, 1'b0);
      chk("rst_rdata", csr_rdata, 32'd0);
      chk("rst_irq", irq_ovf, 1'b0);
      chk("rst_ready", ready_out, 1'b1);
      reset = 1'b0;
      tick(1);

      // address decode table (RS with zero operand leaves every register unchanged)
      for (int k = 0; k < 15; k++) begin
         valid_in = 1'b1; op = RS; csr_wdata = 32'd0;
         csr_addr = dec_tab[k].addr; csr_wena = dec_tab[k].wena;
         #1;
         chk("tab_hit", hit, dec_tab[k].exp_hit);
         chk("tab_illegal", illegal, dec_tab[k].exp_ill);
      end
      valid_in = 1'b0; csr_wena = 1'b0;
      tick(1);

      // basic count and inhibit
      acc(12'h323, RW, 1'b1, 32'd1, rd, h, il);
      events = 8'h01; tick(10); events = 8'h00;
      rd_chk("t1_count", 12'hB03, 32'd10);
      rd_chk("t1_other_cnt", 12'hB04, 32'd0);
      inhibit = 4'h1; events = 8'h01; tick(5); events = 8'h00; inhibit = 4'h0;
      rd_chk("t1_inhibit", 12'hB03, 32'd10);

      // carry into the high half
      acc(12'hB03, RW, 1'b1, 32'hFFFF_FFFF, rd, h, il);
      events = 8'h01; tick(1); events = 8'h00;
      rd_chk("t2_lo", 12'hB03, 32'd0);
      rd_chk("t2_hi", 12'hB83, 32'd1);
      rd_chk("t2_uhi", 12'hC83, 32'd1);
      rd_chk("t2_ulo", 12'hC03, 32'd0);

      // write/increment collision, RS/RC on selector
      events = 8'h01;
      acc(12'hB03, RW, 1'b1, 32'h100, rd, h, il);
      rd_chk("t3_collide", 12'hB03, 32'h100);
      rd_chk("t3_next", 12'hB03, 32'h101);
      events = 8'h00;
      acc(12'h323, RS, 1'b1, 32'h0F, rd, h, il);
      chk("t3_rs_old", rd, 32'd1);
      rd_chk("t3_rs_val", 12'h323, 32'h0F);
      events = 8'hFF; tick(3); events = 8'h00;
      rd_chk("t3_bigsel", 12'hB03, 32'h102);
      rd_chk("t3_hi_kept", 12'hB83, 32'd1);
      acc(12'h323, RC, 1'b1, 32'h0C, rd, h, il);
      rd_chk("t3_rc_val", 12'h323, 32'h03);
      acc(12'h323, RW, 1'b1, 32'd1, rd, h, il);

      // backpressure
      tick(1);
      ready_in = 1'b0; valid_in = 1'b1; csr_addr = 12'hB03; csr_wena = 1'b0; op = RW;
      tick(1);
      chk("t4_valid", valid_out, 1'b1);
      chk("t4_rdata", csr_rdata, 32'h102);
      chk("t4_ready", ready_out, 1'b0);
      csr_wena = 1'b1; csr_wdata = 32'h55; events = 8'h01;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk("t4_hold_valid", valid_out, 1'b1);
         chk("t4_hold_rdata", csr_rdata, 32'h102);
      end
      valid_in = 1'b0; csr_wena = 1'b0; events = 8'h00; ready_in = 1'b1;
      tick(1);
      chk("t4_drain", valid_out, 1'b0);
      rd_chk("t4_counted", 12'hB03, 32'h105);

      // unimplemented index, illegal write, reset mid-transfer
      acc(12'hB07, RW, 1'b1, 32'hDEAD, rd, h, il);
      chk("t5_unimpl_hit", h, 1'b1);
      chk("t5_unimpl_rd", rd, 32'd0);
      rd_chk("t5_unimpl_wr", 12'hB07, 32'd0);
      acc(12'hC03, RW, 1'b1, 32'd0, rd, h, il);
      chk("t5_illegal", il, 1'b1);
      chk("t5_illegal_rd", rd, 32'h105);
      rd_chk("t5_illegal_nowr", 12'hB03, 32'h105);
      tick(1);
      ready_in = 1'b0; valid_in = 1'b1; csr_addr = 12'hB03; csr_wena = 1'b0;
      tick(1);
      chk("t5_pending", valid_out, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_valid", valid_out, 1'b0);
      chk("t5_rst_rdata", csr_rdata, 32'd0);
      #3 reset = 1'b0;
      valid_in = 1'b0; ready_in = 1'b1;
      tick(1);
      rd_chk("t5_rst_cnt", 12'hB03, 32'd0);
      rd_chk("t5_rst_evt", 12'h323, 32'd0);

`ifdef HPM_OVF_IRQ_EN
      // overflow flag and interrupt
      acc(12'h323, RW, 1'b1, 32'h4000_0001, rd, h, il);
      acc(12'hB83, RW, 1'b1, 32'h0000_00FF, rd, h, il);
      acc(12'hB03, RW, 1'b1, 32'hFFFF_FFFF, rd, h, il);
      events = 8'h01; tick(1); events = 8'h00;
      chk("t6_irq_lag", irq_ovf, 1'b0);
      tick(1);
      chk("t6_irq_set", irq_ovf, 1'b1);
      rd_chk("t6_of", 12'h323, 32'hC000_0001);
      rd_chk("t6_lo", 12'hB03, 32'd0);
      rd_chk("t6_hi", 12'hB83, 32'd0);
      acc(12'h323, RC, 1'b1, 32'h8000_0000, rd, h, il);
      tick(1);
      chk("t6_irq_clr", irq_ovf, 1'b0);
      rd_chk("t6_of_clr", 12'h323, 32'h4000_0001);
`else
      chk("t6_irq_tied", irq_ovf, 1'b0);
`endif

      // randomized traffic against the reference model
      reset = 1'b1;
      model_reset();
      #2 reset = 1'b0;
      tick(1);
      for (int c = 0; c < 3000; c++) begin
         valid_in = ($urandom_range(0, 9) < 6);
         ready_in = ($urandom_range(0, 9) < 7);
         csr_addr = pool[$urandom_range(0, 15)];
         op       = 2'($urandom_range(1, 3));
         csr_wena = $urandom_range(0, 1) == 1;
         csr_rena = $urandom_range(0, 1) == 1;
         r        = $urandom_range(0, 3);
         csr_wdata = (r == 0) ? 32'hFFFF_FFFF : ((r == 1) ? 32'hFFFF_FFFE :
                     ((r == 2) ? ($urandom & 32'hC000_0000) | 32'($urandom_range(0, 9)) : $urandom));
         events   = NE'($urandom);
         inhibit  = NC'($urandom & $urandom);
         #1;
         model_step();
         @(posedge clk);
         #1;
         chk("rnd_valid", valid_out, m_valid);
         chk("rnd_rdata", csr_rdata, m_rdata);
         chk("rnd_irq", irq_ovf, m_irq);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
